// File: rtl/altrom_pkg.sv
// Shared sizes and sequencer state encoding for the ALTROM ICE-port arbiter.
package altrom_pkg;

    localparam int ALTROM_AW     = 18;
    localparam int ALTROM_DW     = 32;
    localparam int ALTROM_NWORDS = 6144;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_REJECT  = 2'd3;

endpackage

// File: rtl/altrom_rr_arb2.sv
// Two-way round-robin arbiter; the last pointer moves only when a grant is taken.
module altrom_rr_arb2 (
    input  logic       ck60mhz,
    input  logic       sysrsout,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic last;

    // On a tie the requester that did not win last time goes first
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    always_ff @(posedge ck60mhz) begin
        if (sysrsout) begin
            last <= 1'b1;
        end else if (advance && (grant != 2'b00)) begin
            last <= grant[1];
        end
    end

endmodule

// File: rtl/altrom_ice_arb.sv
// Arbiter and ISSUE/CAPTURE sequencer sharing the ALTROM ICE port between two requesters.
// Define ALTROM_ARB_WPROT_EN to add the wprot input that rejects writes.
module altrom_ice_arb
    import altrom_pkg::*;
#(
    parameter int AW     = ALTROM_AW,
    parameter int DW     = ALTROM_DW,
    parameter int NWORDS = ALTROM_NWORDS
) (
    input  logic          ck60mhz,
    input  logic          sysrsout,
    input  logic          r0_req,
    input  logic          r0_wr,
    input  logic [AW-1:0] r0_ad,
    input  logic [DW-1:0] r0_di,
    output logic          r0_ack,
    output logic          r0_done,
    output logic          r0_err,
    input  logic          r1_req,
    input  logic          r1_wr,
    input  logic [AW-1:0] r1_ad,
    input  logic [DW-1:0] r1_di,
    output logic          r1_ack,
    output logic          r1_done,
    output logic          r1_err,
`ifdef ALTROM_ARB_WPROT_EN
    input  logic          wprot,
`endif
    output logic [DW-1:0] rd_data,
    output logic [AW-1:0] ice_ad,
    output logic [DW-1:0] ice_di,
    output logic          ice_en,
    output logic          ice_wr,
    input  logic [DW-1:0] ice_do
);

    localparam logic [12:0] NW_LIM = NWORDS[12:0];

    logic [1:0]    state;
    logic [1:0]    grant;
    logic          live;
    logic          arb_open;
    logic          g_wr;
    logic [AW-1:0] g_ad;
    logic [DW-1:0] g_di;
    logic          g_pass;
    logic          wr_q;
    logic          id_q;
    logic [DW-1:0] rd_q;
    logic          done_any;

    assign live     = ~sysrsout;
    assign arb_open = live && (state == ST_IDLE);

    altrom_rr_arb2 u_arb (
        .ck60mhz  (ck60mhz),
        .sysrsout (sysrsout),
        .req      ({r1_req, r0_req}),
        .advance  (arb_open),
        .grant    (grant)
    );

    assign r0_ack = arb_open & grant[0];
    assign r1_ack = arb_open & grant[1];

    assign g_wr = grant[1] ? r1_wr : r0_wr;
    assign g_ad = grant[1] ? r1_ad : r0_ad;
    assign g_di = grant[1] ? r1_di : r0_di;

    // Only the low 13 address bits can reach a populated word
    always_comb begin
        g_pass = (g_ad[AW-1:13] == '0) && (g_ad[12:0] < NW_LIM);
`ifdef ALTROM_ARB_WPROT_EN
        if (g_wr && wprot) begin
            g_pass = 1'b0;
        end
`endif
    end

    always_ff @(posedge ck60mhz) begin
        if (sysrsout) begin
            state  <= ST_IDLE;
            wr_q   <= 1'b0;
            id_q   <= 1'b0;
            rd_q   <= '0;
            ice_ad <= '0;
            ice_di <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant != 2'b00) begin
                        wr_q <= g_wr;
                        id_q <= grant[1];
                        if (g_pass) begin
                            ice_ad <= g_ad;
                            ice_di <= g_di;
                            state  <= ST_ISSUE;
                        end else begin
                            state  <= ST_REJECT;
                        end
                    end
                end
                ST_ISSUE: state <= ST_CAPTURE;
                ST_CAPTURE: begin
                    if (!wr_q) begin
                        rd_q <= ice_do;
                    end
                    state <= ST_IDLE;
                end
                default: begin
                    rd_q  <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ice_en   = (state == ST_ISSUE);
    assign ice_wr   = ice_en & wr_q;
    assign done_any = live && ((state == ST_CAPTURE) || (state == ST_REJECT));
    assign r0_done  = done_any & ~id_q;
    assign r1_done  = done_any & id_q;
    assign r0_err   = live && (state == ST_REJECT) && !id_q;
    assign r1_err   = live && (state == ST_REJECT) && id_q;

    // Read data is passed straight through in its done cycle, then held
    always_comb begin
        rd_data = rd_q;
        if (live && (state == ST_CAPTURE) && !wr_q) begin
            rd_data = ice_do;
        end else if (live && (state == ST_REJECT)) begin
            rd_data = '0;
        end
    end

endmodule
